dot_sched: RTL and testbench

- Sequences a matrix-vector product through the shared VSIZE-lane float dot-product datapath.
- Reads one matrix row per cycle from a row memory and issues it with a held operand vector.
- Tracks in-flight rows by a latency tag pipe, not by the datapath's done pulse; buffers results in a FIFO with ready/valid backpressure.
- Sits between the row memory / host control and the dot-product unit.

---
 rtl/dot_sched.sv | 132 +++++++++++++
 tb/tb_dot_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_sched.sv
// dot_sched: streams matrix rows through a shared dot-product datapath and buffers results in order
module dot_sched #(
  parameter int VSIZE      = 4,
  parameter int LAT        = 8,
  parameter int ROW_AW     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ROW_AW-1:0]     num_rows,
  input  logic                  vec_load,
  input  logic [VSIZE*32-1:0]   vec_in,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ROW_AW-1:0]     mem_addr,
  input  logic [VSIZE*32-1:0]   mem_rdata,
  output logic                  dp_en,
  output logic [VSIZE*32-1:0]   dp_in1,
  output logic [VSIZE*32-1:0]   dp_in2,
  input  logic [31:0]           dp_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [31:0]           res_data,
  output logic [ROW_AW-1:0]     res_idx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] FD = (CW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  state_t                   state_q, state_d;
  logic [ROW_AW-1:0]        addr_q, addr_d, left_q, left_d;
  logic [VSIZE*32-1:0]      op_q, op_d;
  logic                     done_q, done_d;
  logic [CW-1:0]            infl_q, infl_d, cnt_q, cnt_d;
  logic [PW-1:0]            wp_q, wp_d, rp_q, rp_d;
  logic [LAT:0]             tv_q, tv_d;
  logic [LAT:0][ROW_AW-1:0] ti_q, ti_d;
  logic [31:0]              fifo_data [FIFO_DEPTH];
  logic [ROW_AW-1:0]        fifo_idx [FIFO_DEPTH];
  logic                     rd, push, pop, empty, full;
  logic [CW:0]              used;
  // Credit: never have more reads outstanding than the FIFO can absorb, counting queued results
  always_comb begin
    used  = {1'b0, infl_q} + {1'b0, cnt_q};
    rd    = (state_q == ISSUE) && (used < FD);
    push  = tv_q[LAT];
    empty = cnt_q == '0;
    full  = cnt_q == CW'(FIFO_DEPTH);
    pop   = !empty && res_ready;
  end
  // Job sequencing: address/row counters advance once per issued read
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = (num_rows == '0) ? FIN : ISSUE;
        addr_d  = '0;
        left_d  = num_rows;
      end
      ISSUE: if (rd) begin
        addr_d  = addr_q + ROW_AW'(1);
        left_d  = left_q - ROW_AW'(1);
        state_d = (left_q == ROW_AW'(1)) ? DRAIN : ISSUE;
      end
      DRAIN: state_d = (infl_q == '0 && empty) ? FIN : DRAIN;
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Operand latch, tag pipe shift, occupancy counters and FIFO pointers
  always_comb begin
    done_d = state_q == FIN;
    op_d   = (state_q == IDLE && vec_load) ? vec_in : op_q;
    tv_d   = {tv_q[LAT-1:0], rd};
    ti_d   = {ti_q[LAT-1:0], addr_q};
    infl_d = infl_q + CW'(rd) - CW'(push);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    wp_d   = wp_q + PW'(push);
    rp_d   = rp_q + PW'(pop);
  end
  // State registers; reset abandons every in-flight row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      op_q    <= '0;
      done_q  <= 1'b0;
      infl_q  <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      tv_q    <= '0;
      ti_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      op_q    <= op_d;
      done_q  <= done_d;
      infl_q  <= infl_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      tv_q    <= tv_d;
      ti_q    <= ti_d;
    end
  end
  // Result storage; contents are only visible through a valid head so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wp_q] <= dp_result;
      fifo_idx[wp_q]  <= ti_q[LAT];
    end
  end
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign mem_rd_en = rd;
  assign mem_addr  = addr_q;
  assign dp_en     = tv_q[0];
  assign dp_in1    = tv_q[0] ? mem_rdata : '0;
  assign dp_in2    = op_q;
  assign res_valid = !empty;
  assign res_data  = empty ? '0 : fifo_data[rp_q];
  assign res_idx   = empty ? '0 : fifo_idx[rp_q];
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && infl_q == '0));
endmodule

// File: tb/tb_dot_sched.sv
// tb_dot_sched: randomized jobs against an in-order row-result model of dot_sched
module tb_dot_sched;
  localparam int VSIZE = 4, LAT = 8, ROW_AW = 8, FD = 16, W = VSIZE*32;
  logic clk = 0, rst_n = 0, start = 0, vec_load = 0, res_ready = 0;
  logic [ROW_AW-1:0] num_rows = '0;
  logic [W-1:0] vec_in = '0, mem_rdata, dp_in1, dp_in2;
  logic busy, done, mem_rd_en, dp_en, res_valid;
  logic [ROW_AW-1:0] mem_addr, res_idx;
  logic [31:0] dp_result, res_data;
  logic [W-1:0] rowmem [256];
  logic [W-1:0] cur_vec = '0;
  logic [31:0] exp_d [$];
  int exp_i [$];
  int iss_q [$];
  logic [31:0] pop_log [$];
  logic [31:0] dpp [LAT];
  int reads = 0, pops = 0, done_cnt = 0, cyc = 0, first_rd = -1, first_rv = -1;
  int n_chk = 0, n_pass = 0, n_fail = 0, ready_mode = 0, job_n = 0;

  always #5 clk = ~clk;

  dot_sched #(.VSIZE(VSIZE), .LAT(LAT), .ROW_AW(ROW_AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .vec_load(vec_load),
    .vec_in(vec_in), .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .dp_en(dp_en), .dp_in1(dp_in1), .dp_in2(dp_in2),
    .dp_result(dp_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx));

  function automatic logic [31:0] i2f(int n);
    int p;
    if (n == 0) return 32'h0;
    p = 31;
    while (p > 0 && !n[p]) p--;
    return {1'b0, 8'(127 + p), 23'(n << (23 - p))};
  endfunction

  function automatic int f2i(logic [31:0] f);
    int e;
    if (f == 32'h0) return 0;
    e = int'(f[30:23]) - 127;
    return int'({1'b1, f[22:0]}) >> (23 - e);
  endfunction

  function automatic logic [31:0] dot(logic [W-1:0] a, logic [W-1:0] b);
    int s = 0;
    for (int i = 0; i < VSIZE; i++) s += f2i(a[i*32 +: 32]) * f2i(b[i*32 +: 32]);
    return i2f(s);
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < VSIZE; i++) v[i*32 +: 32] = i2f(int'($urandom_range(0, 15)));
    return v;
  endfunction

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic fail_now(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // external row memory: data one cycle after the strobe, garbage otherwise
  always @(posedge clk) mem_rdata <= mem_rd_en ? rowmem[mem_addr] : {$urandom, $urandom, $urandom, $urandom};

  // external LAT-stage dot-product unit; non-issued slots carry garbage
  always @(posedge clk) begin
    dpp[0] <= dp_en ? dot(dp_in1, dp_in2) : (32'hBAD00000 ^ cyc);
    for (int k = 1; k < LAT; k++) dpp[k] <= dpp[k-1];
  end
  assign dp_result = dpp[LAT-1];

  always @(posedge clk) begin
    #1;
    res_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  end

  // compare process: reads in order, operands, popped results in row order, credit bound
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_d.delete(); exp_i.delete(); iss_q.delete();
      reads = 0; pops = 0;
    end else begin
      if (dp_en) begin
        if (iss_q.size() == 0) fail_now("dp_en_spurious");
        else begin
          chk("dp_in1", dp_in1, rowmem[iss_q[0]]);
          chk("dp_in2", dp_in2, cur_vec);
          void'(iss_q.pop_front());
        end
      end
      if (mem_rd_en) begin
        chk("rd_addr", W'(mem_addr), W'(reads));
        iss_q.push_back(int'(mem_addr));
        reads++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (res_valid && first_rv < 0) first_rv = cyc;
      if (res_valid && res_ready) begin
        if (exp_d.size() == 0) fail_now("res_spurious");
        else begin
          chk("res_data", W'(res_data), W'(exp_d[0]));
          chk("res_idx", W'(res_idx), W'(exp_i[0]));
          pop_log.push_back(res_data);
          void'(exp_d.pop_front());
          void'(exp_i.pop_front());
        end
        pops++;
      end
      if (reads - pops > FD) fail_now("credit_exceeded");
      if (done) begin
        done_cnt++;
        chk("done_all_popped", W'(exp_d.size()), W'(0));
        chk("done_reads", W'(reads), W'(job_n));
      end
    end
  end

  task automatic start_job(int n, logic [W-1:0] v);
    @(posedge clk); #1;
    vec_in = v; vec_load = 1;
    @(posedge clk); #1;
    vec_load = 0; start = 1; num_rows = ROW_AW'(n);
    cur_vec = v; job_n = n; reads = 0; pops = 0; first_rd = -1; first_rv = -1;
    pop_log.delete();
    for (int i = 0; i < n; i++) begin
      exp_d.push_back(dot(rowmem[i], v));
      exp_i.push_back(i);
    end
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(int maxc);
    int d0, k;
    d0 = done_cnt; k = 0;
    while (done_cnt == d0 && k < maxc) begin @(posedge clk); k++; end
    repeat (3) @(posedge clk);
    chk("done_once", W'(done_cnt - d0), W'(1));
    chk("all_popped", W'(exp_d.size()), W'(0));
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_busy"}, W'(busy), '0);
    chk({tag, "_done"}, W'(done), '0);
    chk({tag, "_rd_en"}, W'(mem_rd_en), '0);
    chk({tag, "_addr"}, W'(mem_addr), '0);
    chk({tag, "_dp_en"}, W'(dp_en), '0);
    chk({tag, "_dp_in1"}, dp_in1, '0);
    chk({tag, "_dp_in2"}, dp_in2, '0);
    chk({tag, "_res_valid"}, W'(res_valid), '0);
    chk({tag, "_res_data"}, W'(res_data), '0);
    chk({tag, "_res_idx"}, W'(res_idx), '0);
  endtask

  task automatic fill_rand(int n);
    for (int i = 0; i < n; i++) rowmem[i] = rand_vec();
  endtask

  initial begin
    logic [31:0] lit [4];
    logic [W-1:0] va, vb;
    int k;
    lit[0] = 32'h40800000; lit[1] = 32'h41000000; lit[2] = 32'h41400000; lit[3] = 32'h41800000;
    for (int i = 0; i < 256; i++) rowmem[i] = '0;
    chk("i2f_1", W'(i2f(1)), W'(32'h3F800000));
    chk("i2f_12", W'(i2f(12)), W'(32'h41400000));
    repeat (2) @(posedge clk); #1;
    check_zero("reset");
    rst_n = 1;

    // basic four-row job against hand-computed results
    ready_mode = 1;
    for (int i = 0; i < 4; i++) rowmem[i] = {VSIZE{i2f(i + 1)}};
    start_job(4, {VSIZE{32'h3F800000}});
    wait_done(200);
    chk("t1_count", W'(pop_log.size()), W'(4));
    for (int i = 0; i < 4; i++) chk("t1_lit", W'(i < pop_log.size() ? pop_log[i] : 32'hFFFFFFFF), W'(lit[i]));
    chk("t1_latency", W'(first_rv - first_rd), W'(LAT + 2));

    // empty job: done two cycles after start, busy for one cycle, no reads
    @(posedge clk); #1;
    start = 1; num_rows = '0; job_n = 0; reads = 0; pops = 0;
    @(negedge clk);
    chk("z_busy_c0", W'(busy), '0);
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("z_busy_c1", W'(busy), W'(1));
    chk("z_done_c1", W'(done), '0);
    @(negedge clk);
    chk("z_busy_c2", W'(busy), '0);
    chk("z_done_c2", W'(done), W'(1));
    @(negedge clk);
    chk("z_done_c3", W'(done), '0);
    chk("z_reads", W'(reads), '0);

    // stalled consumer: exactly FIFO_DEPTH reads, then everything drains in order
    ready_mode = 0;
    fill_rand(40);
    start_job(40, rand_vec());
    repeat (60) @(posedge clk);
    chk("stall_reads", W'(reads), W'(FD));
    chk("stall_valid", W'(res_valid), W'(1));
    ready_mode = 1;
    wait_done(500);
    chk("stall_pops", W'(pops), W'(40));

    // identical rows stay distinct beats
    for (int i = 0; i < 5; i++) rowmem[i] = {32'h0, 32'h0, 32'h3F800000, 32'h3F800000};
    start_job(5, {VSIZE{32'h3F800000}});
    wait_done(200);
    chk("same_count", W'(pop_log.size()), W'(5));
    for (int i = 0; i < pop_log.size(); i++) chk("same_val", W'(pop_log[i]), W'(32'h40000000));

    // randomized jobs with random backpressure
    ready_mode = 2;
    for (int j = 0; j < 6; j++) begin
      k = int'($urandom_range(1, 40));
      fill_rand(k);
      start_job(k, rand_vec());
      wait_done(2000);
      chk("rand_pops", W'(pops), W'(k));
    end

    // start and vec_load while busy are ignored
    fill_rand(12);
    va = rand_vec();
    vb = {VSIZE{i2f(99)}};
    start_job(12, va);
    repeat (3) @(posedge clk); #1;
    vec_in = vb; vec_load = 1; start = 1; num_rows = ROW_AW'(3);
    @(posedge clk); #1;
    vec_load = 0; start = 0;
    wait_done(2000);
    chk("ign_dp_in2", dp_in2, va);
    chk("ign_pops", W'(pops), W'(12));

    // asynchronous reset mid-job, then a clean three-row job
    ready_mode = 1;
    fill_rand(20);
    start_job(20, rand_vec());
    k = 0;
    while (reads < 5 && k < 100) begin @(negedge clk); k++; end
    chk("rst_reads_reached", W'(reads >= 5), W'(1));
    #2 rst_n = 0;
    #1 check_zero("midrst");
    repeat (2) @(posedge clk); #1;
    rst_n = 1;
    repeat (20) @(posedge clk);
    chk("post_rst_idle_valid", W'(res_valid), '0);
    fill_rand(3);
    start_job(3, rand_vec());
    wait_done(200);
    chk("post_rst_pops", W'(pops), W'(3));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
